mux_2x1_rr_ctrl: RTL and testbench

- Packet-level round-robin controller directly upstream of the 2:1 combinational mux.
- Watches the two source valids and last-flit markers and produces the mux's enable and command, plus one-hot grants back to the sources.
- Holds a grant for a whole packet, then alternates priority between the sources.
- Moore-style: all outputs are registered state, so the mux path stays purely combinational.

---
 rtl/mux_2x1_rr_ctrl.sv | 140 ++++++++++++++
 tb/tb_mux_2x1_rr_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_2x1_rr_ctrl.sv
// mux_2x1_rr_ctrl
// Packet-level round-robin controller placed directly upstream of a 2:1
// combinational mux. It grants one source for a whole packet and then
// hands priority to the other source. Every output is a register, so the
// mux select path stays purely combinational.
//
// Optional feature macro: MUX_2X1_RR_CTRL_TIMEOUT_EN
//   When defined, a lock with no flits for TIMEOUT_CYCLES consecutive
//   enabled cycles is force-released and o_timeout pulses for one cycle.
//   When undefined, there is no counter and o_timeout is tied low.
module mux_2x1_rr_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_valid,
    input  logic [1:0] i_last,
    output logic       o_en,
    output logic       o_cmd,
    output logic [1:0] o_grant,
    output logic       o_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCK_LO = 2'd1,
        LOCK_HI = 2'd2
    } state_t;

    state_t state;
    state_t nxt_state;
    logic   prio;
    logic   nxt_prio;
    logic   cur;
    logic   release_lock;

`ifdef MUX_2X1_RR_CTRL_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] nxt_cnt;
    logic                 forced;
`endif

    // A timeout shorter than two cycles would release a lock before the
    // source could ever present its first flit.
    if (TIMEOUT_CYCLES < 2 || CNT_WIDTH < 2) begin : g_bad_timeout
        $error("mux_2x1_rr_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    // Next-state decode: arbitration from IDLE, packet end or forced release from a lock.
    always_comb begin
        cur          = (state == LOCK_HI);
        nxt_state    = state;
        nxt_prio     = prio;
        release_lock = 1'b0;
`ifdef MUX_2X1_RR_CTRL_TIMEOUT_EN
        nxt_cnt      = '0;
        forced       = 1'b0;
`endif
        case (state)
            IDLE: begin
                case (i_valid)
                    2'b01:   nxt_state = LOCK_LO;
                    2'b10:   nxt_state = LOCK_HI;
                    2'b11:   nxt_state = prio ? LOCK_HI : LOCK_LO;
                    default: nxt_state = IDLE;
                endcase
            end
            LOCK_LO, LOCK_HI: begin
                if (i_valid[cur]) begin
                    release_lock = i_last[cur];
                end else begin
`ifdef MUX_2X1_RR_CTRL_TIMEOUT_EN
                    if (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        forced       = 1'b1;
                        release_lock = 1'b1;
                    end else begin
                        nxt_cnt = cnt + 1'b1;
                    end
`endif
                end
                if (release_lock) begin
                    nxt_prio  = ~cur;
                    nxt_state = i_valid[~cur] ? (cur ? LOCK_LO : LOCK_HI) : IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Controller state and registered mux/grant outputs; a low i_en freezes state and blanks the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            prio    <= 1'b0;
            o_en    <= 1'b0;
            o_cmd   <= 1'b0;
            o_grant <= 2'b00;
`ifdef MUX_2X1_RR_CTRL_TIMEOUT_EN
            cnt       <= '0;
            o_timeout <= 1'b0;
`endif
        end else if (i_en) begin
            state <= nxt_state;
            prio  <= nxt_prio;
            case (nxt_state)
                LOCK_LO: begin
                    o_en    <= 1'b1;
                    o_cmd   <= 1'b0;
                    o_grant <= 2'b01;
                end
                LOCK_HI: begin
                    o_en    <= 1'b1;
                    o_cmd   <= 1'b1;
                    o_grant <= 2'b10;
                end
                default: begin
                    o_en    <= 1'b0;
                    o_grant <= 2'b00;
                end
            endcase
`ifdef MUX_2X1_RR_CTRL_TIMEOUT_EN
            cnt       <= nxt_cnt;
            o_timeout <= forced;
`endif
        end else begin
            o_en    <= 1'b0;
            o_grant <= 2'b00;
`ifdef MUX_2X1_RR_CTRL_TIMEOUT_EN
            o_timeout <= 1'b0;
`endif
        end
    end

`ifndef MUX_2X1_RR_CTRL_TIMEOUT_EN
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux_2x1_rr_ctrl.sv
// tb_mux_2x1_rr_ctrl
// Scoreboard bench: a packet-level reference model predicts the registered
// outputs at every rising edge and queues them; a monitor pops and compares
// on every falling edge. Directed packet sequences are followed by random
// traffic. Builds with or without MUX_2X1_RR_CTRL_TIMEOUT_EN.
module tb_mux_2x1_rr_ctrl;

    localparam int TO = 4;

    typedef struct packed {
        logic       en;
        logic       cmd;
        logic [1:0] grant;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_en = 1'b0;
    logic [1:0] i_valid = 2'b00;
    logic [1:0] i_last = 2'b00;
    logic       o_en;
    logic       o_cmd;
    logic [1:0] o_grant;
    logic       o_timeout;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // Reference model state: owner is -1 when nobody holds the mux
    int   m_owner = -1;
    int   m_prio = 0;
    int   m_silent = 0;
    logic m_cmd = 1'b0;

    mux_2x1_rr_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (i_en),
        .i_valid   (i_valid),
        .i_last    (i_last),
        .o_en      (o_en),
        .o_cmd     (o_cmd),
        .o_grant   (o_grant),
        .o_timeout (o_timeout)
    );

    always #5 clk = ~clk;

    // Compare the live DUT outputs against one expected record
    task automatic checkOutput(input string name, input exp_t exp);
        exp_t act;
        act = '{en: o_en, cmd: o_cmd, grant: o_grant, to: o_timeout};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cyc=%0d got en=%b cmd=%b grant=%b to=%b expected en=%b cmd=%b grant=%b to=%b",
                     name, cyc, act.en, act.cmd, act.grant, act.to,
                     exp.en, exp.cmd, exp.grant, exp.to);
        end
    endtask

    // Drive one input pattern for n cycles, changing inputs on falling edges
    task automatic applyStimulus(input logic en, input logic [1:0] v,
                                 input logic [1:0] l, input int n);
        i_en    = en;
        i_valid = v;
        i_last  = l;
        repeat (n) @(negedge clk);
    endtask

    // Packet-level behaviour of the controller for one rising edge
    task automatic modelStep();
        exp_t e;
        int   o;
        logic rel;
        logic to;
        e   = '0;
        rel = 1'b0;
        to  = 1'b0;
        if (!rst_n) begin
            m_owner  = -1;
            m_prio   = 0;
            m_silent = 0;
            m_cmd    = 1'b0;
        end else if (!i_en) begin
            e.cmd = m_cmd;
        end else begin
            if (m_owner < 0) begin
                if (i_valid == 2'b11) m_owner = m_prio;
                else if (i_valid[0]) m_owner = 0;
                else if (i_valid[1]) m_owner = 1;
                m_silent = 0;
            end else begin
                o = m_owner;
                if (i_valid[o]) begin
                    m_silent = 0;
                    rel = i_last[o];
                end else begin
`ifdef MUX_2X1_RR_CTRL_TIMEOUT_EN
                    m_silent++;
                    if (m_silent >= TO) begin
                        rel = 1'b1;
                        to  = 1'b1;
                    end
`endif
                end
                if (rel) begin
                    m_prio   = 1 - o;
                    m_owner  = i_valid[1 - o] ? 1 - o : -1;
                    m_silent = 0;
                end
            end
            if (m_owner >= 0) begin
                m_cmd   = (m_owner == 1);
                e.en    = 1'b1;
                e.grant = (m_owner == 1) ? 2'b10 : 2'b01;
            end
            e.cmd = m_cmd;
            e.to  = to;
        end
        exp_q.push_back(e);
    endtask

    // Scoreboard producer: predict the outputs each rising edge will register
    initial begin
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    // Scoreboard consumer: compare on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL scoreboard cyc=%0d got empty queue expected a prediction", cyc);
            end else begin
                checkOutput("outputs", exp_q.pop_front());
            end
        end
    end

    // Stimulus: directed packet scenarios, then random traffic
    initial begin
        logic [1:0] v;
        logic [1:0] l;
        exp_t       zero;
        zero = '0;

        // Reset held with both sources requesting, then release
        applyStimulus(1'b1, 2'b11, 2'b00, 3);
        rst_n = 1'b1;
        applyStimulus(1'b1, 2'b11, 2'b00, 1);
        applyStimulus(1'b1, 2'b01, 2'b01, 1);

        // High source sends a 4-flit packet while low keeps requesting
        applyStimulus(1'b1, 2'b11, 2'b00, 1);
        applyStimulus(1'b1, 2'b11, 2'b00, 3);
        applyStimulus(1'b1, 2'b11, 2'b10, 1);
        applyStimulus(1'b1, 2'b01, 2'b01, 1);
        applyStimulus(1'b1, 2'b00, 2'b00, 1);

        // Single-flit packets from both sources alternate every cycle
        applyStimulus(1'b1, 2'b11, 2'b11, 6);
        applyStimulus(1'b1, 2'b00, 2'b11, 2);

        // Freeze in the middle of a low-source packet
        applyStimulus(1'b1, 2'b01, 2'b00, 2);
        applyStimulus(1'b0, 2'b01, 2'b00, 3);
        applyStimulus(1'b1, 2'b01, 2'b00, 1);
        applyStimulus(1'b1, 2'b01, 2'b01, 1);
        applyStimulus(1'b1, 2'b00, 2'b00, 2);

        // Locked source goes quiet, then resumes; last without valid is ignored
        applyStimulus(1'b1, 2'b10, 2'b00, 1);
        applyStimulus(1'b1, 2'b00, 2'b10, 5);
        applyStimulus(1'b1, 2'b10, 2'b00, 1);

        // Asynchronous reset mid-packet drops the lock at once
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset", zero);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 2'b00, 2'b00, 1);
        applyStimulus(1'b1, 2'b11, 2'b00, 1);

        // Low keeps the lock then goes silent while high requests
        applyStimulus(1'b1, 2'b01, 2'b00, 1);
        applyStimulus(1'b1, 2'b10, 2'b00, 4);
        applyStimulus(1'b1, 2'b10, 2'b10, 1);
        applyStimulus(1'b1, 2'b00, 2'b00, 2);

        // Random traffic with occasional freezes and quiet stretches
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                v = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
                applyStimulus(1'b1, v, 2'b00, $urandom_range(3, 6));
            end else begin
                v = 2'($urandom_range(0, 3));
                l = 2'($urandom_range(0, 3));
                applyStimulus(($urandom_range(0, 9) != 0), v, l, 1);
            end
        end

        applyStimulus(1'b1, 2'b00, 2'b00, 2);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain got %0d pending predictions expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
